// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   DATA_WIDTH / ADDR_WIDTH : write data and register index widths
//   NUM_REGS                : register file depth
//   ZERO_REG                : hard-zero register; writes to it are discarded
//   wb_req_t                : one buffered write {register index, data}
//   age_rel_e               : relative age of the two holding slots
package reg_write_arbiter_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] idx;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    // Only meaningful while both slots are full.
    typedef enum logic [1:0] {
        AGE_EQUAL   = 2'd0,
        AGE_A_OLDER = 2'd1,
        AGE_B_OLDER = 2'd2
    } age_rel_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_WIDTH-1:0] idx);
        logic [NUM_REGS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_wb_hold_slot.sv
// Single-entry writeback holding buffer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : empties the slot at the edge (highest priority)
//   load_i        : capture req_i at the edge (may coincide with a drain)
//   drain_i       : the held write is committed at this edge
//   req_i         : incoming {index, data}
//   full_o        : slot holds a write
//   reg_o, data_o : held index and data
//   mask_o        : one-hot of the held index, zero when empty
module wb_hold_slot
    import reg_write_arbiter_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  load_i,
    input  logic                  drain_i,
    input  wb_req_t               req_i,
    output logic                  full_o,
    output logic [ADDR_WIDTH-1:0] reg_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [NUM_REGS-1:0]   mask_o
);

    logic    full_q, full_d;
    wb_req_t req_q,  req_d;

    // A load on the same edge as a drain simply reloads the slot.
    always_comb begin
        full_d = full_q;
        req_d  = req_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d = 1'b1;
            req_d  = req_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            req_q  <= '0;
        end else begin
            full_q <= full_d;
            req_q  <= req_d;
        end
    end

    assign full_o = full_q;
    assign reg_o  = req_q.idx;
    assign data_o = req_q.data;
    assign mask_o = full_q ? reg_onehot(req_q.idx) : '0;

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port between the ALU writeback path (A)
// and the load writeback path (B). Each has a one-entry holding slot; full
// slots drain oldest-first, one per cycle, ties broken by a toggling pointer.
//   CLK, RESET_N              : clock, asynchronous active-low reset
//   FLUSH                     : drops both slots, blocks writes and handshakes
//   A_VALID/A_REG/A_DATA/A_READY : requester A handshake
//   B_VALID/B_REG/B_DATA/B_READY : requester B handshake
//   WRITE_REG/WRITE_DATA/REG_WRITE_ENABLE : register-file write port
//   PENDING_MASK              : registers targeted by a buffered write
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  FLUSH,
    input  logic                  A_VALID,
    input  logic [ADDR_WIDTH-1:0] A_REG,
    input  logic [DATA_WIDTH-1:0] A_DATA,
    output logic                  A_READY,
    input  logic                  B_VALID,
    input  logic [ADDR_WIDTH-1:0] B_REG,
    input  logic [DATA_WIDTH-1:0] B_DATA,
    output logic                  B_READY,
    output logic [ADDR_WIDTH-1:0] WRITE_REG,
    output logic [DATA_WIDTH-1:0] WRITE_DATA,
    output logic                  REG_WRITE_ENABLE,
    output logic [NUM_REGS-1:0]   PENDING_MASK
);

    logic                  full_a, full_b;
    logic [ADDR_WIDTH-1:0] reg_a, reg_b;
    logic [DATA_WIDTH-1:0] data_a, data_b;
    logic [NUM_REGS-1:0]   mask_a, mask_b;
    wb_req_t               req_a, req_b;

    logic     grant_a, grant_b;
    logic     drain_a, drain_b;
    logic     load_a, load_b;
    logic     stay_a, stay_b;
    age_rel_e age_q, age_d;
    logic     rr_q, rr_d;

    assign req_a.idx  = A_REG;
    assign req_a.data = A_DATA;
    assign req_b.idx  = B_REG;
    assign req_b.data = B_DATA;

    // Grant: a lone full slot wins; with both full the older wins, and a
    // same-edge pair is ordered by the tie-break pointer (0 = A first).
    assign grant_a = full_a & (~full_b
                               | (age_q == AGE_A_OLDER)
                               | ((age_q == AGE_EQUAL) & ~rr_q));
    assign grant_b = full_b & ~grant_a;

    assign drain_a = grant_a & ~FLUSH;
    assign drain_b = grant_b & ~FLUSH;

    // A slot that is draining this edge can accept a replacement.
    assign A_READY = (~full_a | grant_a) & ~FLUSH;
    assign B_READY = (~full_b | grant_b) & ~FLUSH;

    // Writes to the hard-zero register complete the handshake but are
    // never buffered.
    assign load_a = A_VALID & A_READY & (A_REG != ZERO_REG);
    assign load_b = B_VALID & B_READY & (B_REG != ZERO_REG);

    // Slots still holding their old entry after this edge.
    assign stay_a = full_a & ~drain_a;
    assign stay_b = full_b & ~drain_b;

    always_comb begin
        age_d = age_q;
        if (FLUSH) begin
            age_d = AGE_EQUAL;
        end else if (load_a && load_b) begin
            age_d = AGE_EQUAL;
        end else if (load_a && stay_b) begin
            age_d = AGE_B_OLDER;
        end else if (load_b && stay_a) begin
            age_d = AGE_A_OLDER;
        end
    end

    // The pointer advances only when it actually decided a write.
    assign rr_d = rr_q ^ (full_a & full_b & (age_q == AGE_EQUAL) & ~FLUSH);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            age_q <= AGE_EQUAL;
            rr_q  <= 1'b0;
        end else begin
            age_q <= age_d;
            rr_q  <= rr_d;
        end
    end

    wb_hold_slot u_slot_a (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .flush_i (FLUSH),
        .load_i  (load_a),
        .drain_i (drain_a),
        .req_i   (req_a),
        .full_o  (full_a),
        .reg_o   (reg_a),
        .data_o  (data_a),
        .mask_o  (mask_a)
    );

    wb_hold_slot u_slot_b (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .flush_i (FLUSH),
        .load_i  (load_b),
        .drain_i (drain_b),
        .req_i   (req_b),
        .full_o  (full_b),
        .reg_o   (reg_b),
        .data_o  (data_b),
        .mask_o  (mask_b)
    );

    assign REG_WRITE_ENABLE = (full_a | full_b) & ~FLUSH;

    always_comb begin
        WRITE_REG  = '0;
        WRITE_DATA = '0;
        if (grant_a) begin
            WRITE_REG  = reg_a;
            WRITE_DATA = data_a;
        end else if (grant_b) begin
            WRITE_REG  = reg_b;
            WRITE_DATA = data_b;
        end
    end

    assign PENDING_MASK = (mask_a | mask_b) & ~reg_onehot(ZERO_REG);

endmodule
